// File: rtl/xcorr_pkg.sv
// Shared types and helpers for the cross-correlation result readers.
package xcorr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A signed lag spans the full address range on both sides of the centre.
   function automatic int lag_width(input int addr_width);
      return addr_width + 1;
   endfunction

endpackage

// File: rtl/xcorr_peak_find_if.sv
// Read port of the correlator result RAM; master issues address/enable, slave returns data.
interface xcorr_peak_find_if #(
   parameter int OUT_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH     = 8
);
   logic [OUT_ADDR_WIDTH-1:0] s_addr;
   logic                      s_rden;
   logic [DATA_WIDTH-1:0]     s_q;

   modport master (output s_addr, output s_rden, input  s_q);
   modport slave  (input  s_addr, input  s_rden, output s_q);
endinterface

// File: rtl/xcorr_peak_find_rd_tag_pipe.sv
// {valid, addr} shift register that tracks reads in flight through a RAM of fixed latency.
module rd_tag_pipe #(
   parameter int DEPTH      = 1,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  in_valid,
   input  logic [ADDR_WIDTH-1:0] in_addr,
   output logic                  out_valid,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  any_valid
);

   logic [DEPTH-1:0]      vld;
   logic [ADDR_WIDTH-1:0] adr [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld <= '0;
         for (int i = 0; i < DEPTH; i++) adr[i] <= '0;
      end else begin
         vld[0] <= in_valid;
         adr[0] <= in_addr;
         for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            adr[i] <= adr[i-1];
         end
      end
   end

   assign out_valid = vld[DEPTH-1];
   assign out_addr  = adr[DEPTH-1];
   assign any_valid = |vld;

endmodule

// File: rtl/xcorr_peak_find.sv
// Scans the correlator result buffer once per start and reports the maximum, its address and lag.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing reads for addresses 0..N-1
// DRAIN | reads issued, waiting for the last data to be compared
// DONE  | one-cycle done pulse, results loaded
module xcorr_peak_find
   import xcorr_pkg::*;
#(
   parameter int OUT_ADDR_WIDTH = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int RD_LATENCY     = 1,
   parameter int LAG_CENTER     = 128,
   parameter int MIN_PEAK       = 1
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic                                  start,
   xcorr_peak_find_if.master                     rd,
   output logic                                  busy,
   output logic                                  done,
   output logic [DATA_WIDTH-1:0]                 peak_val,
   output logic [OUT_ADDR_WIDTH-1:0]             peak_idx,
   output logic [lag_width(OUT_ADDR_WIDTH)-1:0]  peak_lag,
   output logic                                  found
);

   localparam int LW = lag_width(OUT_ADDR_WIDTH);

   state_t                    state;
   logic                      tag_valid;
   logic [OUT_ADDR_WIDTH-1:0] tag_addr;
   logic                      tag_any;
   logic [DATA_WIDTH-1:0]     max_val;
   logic [OUT_ADDR_WIDTH-1:0] max_idx;

   rd_tag_pipe #(
      .DEPTH      (RD_LATENCY),
      .ADDR_WIDTH (OUT_ADDR_WIDTH)
   ) u_rd_tag_pipe (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (rd.s_rden),
      .in_addr   (rd.s_addr),
      .out_valid (tag_valid),
      .out_addr  (tag_addr),
      .any_valid (tag_any)
   );

   // Address 0 seeds the running max; strict compare keeps the lowest address on ties.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         max_val <= '0;
         max_idx <= '0;
      end else if (tag_valid) begin
         if (tag_addr == '0 || rd.s_q > max_val) begin
            max_val <= rd.s_q;
            max_idx <= tag_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         rd.s_addr <= '0;
         rd.s_rden <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         peak_val  <= '0;
         peak_idx  <= '0;
         peak_lag  <= '0;
         found     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= SCAN;
                  rd.s_addr <= '0;
                  rd.s_rden <= 1'b1;
                  busy      <= 1'b1;
               end
            end
            SCAN: begin
               if (rd.s_addr == '1) begin
                  state     <= DRAIN;
                  rd.s_rden <= 1'b0;
               end else begin
                  rd.s_addr <= rd.s_addr + 1'b1;
               end
            end
            DRAIN: begin
               // Empty pipe means the final compare has already landed in max_val/max_idx.
               if (!tag_any) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  peak_val <= max_val;
                  peak_idx <= max_idx;
                  peak_lag <= {1'b0, max_idx} - LW'(LAG_CENTER);
                  found    <= (max_val >= DATA_WIDTH'(MIN_PEAK));
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_xcorr_peak_find.sv
// Directed bench: two instances (RAM latency 1 and 2) reading a shared behavioural buffer.
module tb_xcorr_peak_find;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_a, start_b;
   logic [7:0] mem [256];

   logic       busy_a, done_a, found_a, busy_b, done_b, found_b;
   logic [7:0] val_a, idx_a, val_b, idx_b;
   logic [8:0] lag_a, lag_b;
   logic [7:0] qa, qb1, qb2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   xcorr_peak_find_if #(.OUT_ADDR_WIDTH(8), .DATA_WIDTH(8)) if_a ();
   xcorr_peak_find_if #(.OUT_ADDR_WIDTH(8), .DATA_WIDTH(8)) if_b ();

   xcorr_peak_find #(.RD_LATENCY(1)) dut_a (
      .clk(clk), .reset_n(reset_n), .start(start_a), .rd(if_a.master),
      .busy(busy_a), .done(done_a), .peak_val(val_a), .peak_idx(idx_a),
      .peak_lag(lag_a), .found(found_a)
   );

   xcorr_peak_find #(.RD_LATENCY(2)) dut_b (
      .clk(clk), .reset_n(reset_n), .start(start_b), .rd(if_b.master),
      .busy(busy_b), .done(done_b), .peak_val(val_b), .peak_idx(idx_b),
      .peak_lag(lag_b), .found(found_b)
   );

   always @(posedge clk) begin
      if (if_a.s_rden) qa <= mem[if_a.s_addr];
      if (if_b.s_rden) qb1 <= mem[if_b.s_addr];
      qb2 <= qb1;
   end
   assign if_a.s_q = qa;
   assign if_b.s_q = qb2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] lag_of(input int idx);
      return 9'(idx - 128);
   endfunction

   task automatic set_start(input int s, input logic v);
      if (s == 0) start_a = v; else start_b = v;
   endtask

   function automatic logic get_done(input int s);
      return (s == 0) ? done_a : done_b;
   endfunction
   function automatic logic get_rden(input int s);
      return (s == 0) ? if_a.s_rden : if_b.s_rden;
   endfunction
   function automatic logic [7:0] get_addr(input int s);
      return (s == 0) ? if_a.s_addr : if_b.s_addr;
   endfunction

   task automatic fill(input logic [7:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   // Edge 0 samples start; returns the edge index after which done was first seen.
   task automatic do_scan(input int s, input bit extra_starts,
                          output int edges, output int n_done, output int addr_err);
      int exp_addr;
      edges = -1; n_done = 0; addr_err = 0; exp_addr = 0;
      @(negedge clk);
      set_start(s, 1'b1);
      for (int n = 0; n <= 300; n++) begin
         @(posedge clk); #1;
         set_start(s, 1'b0);
         if (extra_starts && (n + 1 == 10 || n + 1 == 200)) set_start(s, 1'b1);
         if (get_rden(s)) begin
            if (get_addr(s) != 8'(exp_addr)) addr_err++;
            exp_addr++;
         end
         if (get_done(s)) begin
            n_done++;
            if (edges < 0) edges = n;
         end
      end
      if (exp_addr != 256) addr_err++;
   endtask

   task automatic check_a(input string tag, input int v, input int idx, input logic f);
      chk({tag, "_val"},   val_a, 32'(v));
      chk({tag, "_idx"},   idx_a, 32'(idx));
      chk({tag, "_lag"},   lag_a, lag_of(idx));
      chk({tag, "_found"}, found_a, f);
   endtask

   int edges, n_done, addr_err, extra_done;

   initial begin
      reset_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      fill(8'd0);
      #23;
      chk("rst_addr",  if_a.s_addr, 0);
      chk("rst_rden",  if_a.s_rden, 0);
      chk("rst_busy",  busy_a, 0);
      chk("rst_done",  done_a, 0);
      chk("rst_val",   val_a, 0);
      chk("rst_idx",   idx_a, 0);
      chk("rst_lag",   lag_a, 0);
      chk("rst_found", found_a, 0);
      @(negedge clk); reset_n = 1'b1;

      // Single peak
      fill(8'd5); mem[37] = 8'd200;
      do_scan(0, 1'b0, edges, n_done, addr_err);
      chk("peak_latency", edges, 258);
      chk("peak_ndone", n_done, 1);
      chk("peak_addrseq", addr_err, 0);
      check_a("peak", 200, 37, 1'b1);
      chk("peak_busy_idle", busy_a, 0);
      chk("peak_addr_hold", if_a.s_addr, 255);

      // Tie keeps lowest address
      fill(8'd3); mem[50] = 8'd180; mem[90] = 8'd180;
      do_scan(0, 1'b0, edges, n_done, addr_err);
      check_a("tie", 180, 50, 1'b1);

      // All zero, then single 1 at the last address
      fill(8'd0);
      do_scan(0, 1'b0, edges, n_done, addr_err);
      check_a("zero", 0, 0, 1'b0);
      mem[255] = 8'd1;
      do_scan(0, 1'b0, edges, n_done, addr_err);
      check_a("last", 1, 255, 1'b1);

      // Protocol: starts during the scan are ignored
      fill(8'd5); mem[37] = 8'd200;
      do_scan(0, 1'b1, edges, n_done, addr_err);
      chk("proto_a_latency", edges, 258);
      chk("proto_a_ndone", n_done, 1);
      chk("proto_a_addrseq", addr_err, 0);
      check_a("proto_a", 200, 37, 1'b1);
      do_scan(1, 1'b1, edges, n_done, addr_err);
      chk("proto_b_latency", edges, 259);
      chk("proto_b_ndone", n_done, 1);
      chk("proto_b_addrseq", addr_err, 0);
      chk("proto_b_val", val_b, 200);
      chk("proto_b_idx", idx_b, 37);
      chk("proto_b_lag", lag_b, lag_of(37));
      chk("proto_b_found", found_b, 1);

      // Reset mid-scan
      fill(8'd7); mem[200] = 8'd99;
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      repeat (100) @(posedge clk);
      #1; reset_n = 1'b0; #1;
      chk("mrst_addr",  if_a.s_addr, 0);
      chk("mrst_rden",  if_a.s_rden, 0);
      chk("mrst_busy",  busy_a, 0);
      chk("mrst_val",   val_a, 0);
      chk("mrst_idx",   idx_a, 0);
      chk("mrst_lag",   lag_a, 0);
      chk("mrst_found", found_a, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      extra_done = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (done_a) extra_done++;
      end
      chk("mrst_no_done", extra_done, 0);
      do_scan(0, 1'b0, edges, n_done, addr_err);
      chk("mrst_latency", edges, 258);
      check_a("mrst_rescan", 99, 200, 1'b1);

      // Hold: buffer changes without start leave results alone
      fill(8'd250);
      extra_done = 0;
      repeat (300) begin
         @(posedge clk); #1;
         if (done_a) extra_done++;
      end
      chk("hold_no_done", extra_done, 0);
      check_a("hold", 99, 200, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xcorr_peak_find.md
Name: xcorr_peak_find

Overview:
- Reads the cross-correlation result buffer that the correlator fills, one word per address, 0 to 2^OUT_ADDR_WIDTH-1.
- Finds the largest correlation value, its address, and the signed lag relative to the zero-delay address.
- Sits between the correlator's output RAM read port and the beam-steering/direction logic.
- Started by the correlator's completion flag; reports results with a one-cycle done pulse.

Parameters:
- OUT_ADDR_WIDTH, 8, address width of the result buffer; N = 2^OUT_ADDR_WIDTH entries.
- DATA_WIDTH, 8, width of each unsigned result word.
- RD_LATENCY, 1, read latency of the RAM in clock cycles (1 or 2), from the address being presented to the data being returned.
- LAG_CENTER, 128, address that corresponds to zero lag.
- MIN_PEAK, 1, smallest peak value that counts as a detection.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to scan the buffer; sampled only in IDLE.
- s_addr  out  OUT_ADDR_WIDTH  read address into the result buffer.
- s_rden  out  1  read enable.
- s_q  in  DATA_WIDTH  read data, returned RD_LATENCY cycles after s_addr/s_rden.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results update.
- peak_val  out  DATA_WIDTH  maximum value found.
- peak_idx  out  OUT_ADDR_WIDTH  address of the maximum.
- peak_lag  out  OUT_ADDR_WIDTH+1  signed lag, equal to peak_idx - LAG_CENTER (two's complement).
- found  out  1  1 when peak_val >= MIN_PEAK.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State returns to IDLE.
  - All outputs are 0: s_addr, s_rden, busy, done, peak_val, peak_idx, peak_lag, found.
  - Internal max/index registers and the read-tag pipeline are cleared.
  - A reset in the middle of a scan abandons the scan; no done is produced.
- States:
  - IDLE: on start=1, go to SCAN with the address counter at 0.
  - SCAN: s_rden=1 and s_addr=counter; the counter increments each cycle; after address N-1 is issued, go to DRAIN.
  - DRAIN: s_rden=0; wait until the tag pipeline (depth RD_LATENCY) is empty, then go to DONE.
  - DONE: for one cycle, done=1 and busy=0, and the result outputs are loaded; then return to IDLE.
- Read tagging: each issued read pushes {valid, addr} into a shift register of depth RD_LATENCY. When a valid tag emerges, s_q is paired with that address.
- Compare stage, for each valid tag:
  - The first element (address 0) loads max=s_q, idx=0 unconditionally.
  - Every later element updates only if s_q > max (strictly greater). Ties keep the lowest address.
  - The comparison is unsigned and DATA_WIDTH wide; no accumulation, so no overflow is possible.
- Latency: from the edge that samples start, done rises after exactly N + RD_LATENCY + 1 edges. This is 258 edges for the defaults.
- Result outputs:
  - Update only in DONE and hold their values until the next DONE or reset.
  - peak_lag = zero-extended peak_idx minus LAG_CENTER, computed in OUT_ADDR_WIDTH+1 bits.
  - found = (peak_val >= MIN_PEAK).
- Handshake and boundaries:
  - start while busy, or in DONE, is ignored (no queuing).
  - start held high across DONE into IDLE begins a new scan.
  - The address counter never wraps mid-scan: SCAN ends on address N-1.
  - s_addr holds its last value (N-1) outside SCAN.
- The block never writes the buffer. The system must ensure the correlator is idle during a scan; the block does not check this.

Decomposition:
- Shared package xcorr_pkg:
  - state_t enum (IDLE, SCAN, DRAIN, DONE), shared with the correlator's state style.
  - lag width localparam function.
- One natural sub-module: rd_tag_pipe, a parameterised {valid, addr} shift register of depth RD_LATENCY. The correlator's future read paths can reuse it.
- Compare and control logic stay in the top module.

Test Plan:
- Single peak: buffer all 5 except addr 37 = 200; pulse start → done after 258 edges, peak_val=200, peak_idx=37, peak_lag=-91, found=1.
- Tie: addr 50 = 180 and addr 90 = 180, rest 3 → peak_idx=50, peak_val=180.
- All zero with MIN_PEAK=1 → peak_val=0, peak_idx=0, peak_lag=-128, found=0; then addr 255 = 1, rescan → peak_idx=255, peak_lag=+127, found=1.
- Protocol: start pulsed again at cycles 10 and 200 of a scan → ignored, exactly one done, s_addr visits 0..255 once each in order; also re-run with RD_LATENCY=2 → done after 259 edges, same results.
- Reset mid-scan: reset_n low at scan cycle 100 → all outputs 0 immediately, no done pulse; after release, start → normal correct scan.
- Hold: after done, change buffer contents without start → peak outputs unchanged.
